// File: rtl/raw10_unpacker_if.sv
// Payload-in / pixels-out bundle between the MIPI packet receiver, the RAW10
// unpacker and the frame-buffer arbiter.
interface raw10_unpacker_if;
   logic [3:0][7:0] image_data;
   logic [5:0]      image_data_type;
   logic            image_data_enable;
   logic            frame_start;
   logic [3:0][9:0] pixel;
   logic            pixel_enable;
   logic            line_done;
   logic [15:0]     line_pixel_count;
   logic            align_err;

   modport master (
      output image_data, image_data_type, image_data_enable, frame_start,
      input  pixel, pixel_enable, line_done, line_pixel_count, align_err
   );

   modport slave (
      input  image_data, image_data_type, image_data_enable, frame_start,
      output pixel, pixel_enable, line_done, line_pixel_count, align_err
   );
endinterface

// File: rtl/raw10_unpacker.sv
// CSI-2 RAW10 unpacker: 4-byte payload beats through a 5-byte gearbox into
// groups of four 10-bit pixels, with per-line pixel count and alignment error.
module raw10_unpacker #(
   parameter logic [5:0] DATA_TYPE = 6'h2B
) (
   input logic            mipi_clk,
   input logic            reset_n,
   raw10_unpacker_if.slave bus
);

   logic [63:0]     buf_q;
   logic [2:0]      res_q;
   logic            in_packet_q;
   logic            accept_q;
   logic [15:0]     count_q;
   logic [3:0][9:0] pixel_q;
   logic            pixel_enable_q;
   logic            line_done_q;
   logic [15:0]     line_pixel_count_q;
   logic            align_err_q;

   logic            firstBeat;
   logic            acceptNow;
   logic            beatTaken;
   logic            packetEnd;
   logic [3:0]      total;
   logic            emit;
   logic [63:0]     merged_d;
   logic [39:0]     group;

   // Byte 0 of the buffer sits in the low bits; bytes above the residue are
   // masked so the new beat lands directly after the held bytes.
   always_comb begin
      firstBeat = bus.image_data_enable && !in_packet_q;
      acceptNow = firstBeat ? (bus.image_data_type == DATA_TYPE) : accept_q;
      beatTaken = bus.image_data_enable && acceptNow;
      packetEnd = !bus.image_data_enable && in_packet_q;
      total     = {1'b0, res_q} + 4'd4;
      emit      = beatTaken && (total >= 4'd5);
      merged_d  = (buf_q & ~(64'hFFFF_FFFF_FFFF_FFFF << {res_q, 3'b000}))
                | ({32'h0, bus.image_data} << {res_q, 3'b000});
      group     = merged_d[39:0];
   end

   always_ff @(posedge mipi_clk or negedge reset_n) begin
      if (!reset_n) begin
         buf_q              <= '0;
         res_q              <= '0;
         in_packet_q        <= 1'b0;
         accept_q           <= 1'b0;
         count_q            <= '0;
         pixel_q            <= '0;
         pixel_enable_q     <= 1'b0;
         line_done_q        <= 1'b0;
         line_pixel_count_q <= '0;
         align_err_q        <= 1'b0;
      end else begin
         pixel_enable_q <= emit;
         line_done_q    <= packetEnd && accept_q;

         if (firstBeat) begin
            in_packet_q <= 1'b1;
            accept_q    <= acceptNow;
         end else if (packetEnd) begin
            in_packet_q <= 1'b0;
         end

         if (beatTaken) begin
            if (emit) begin
               buf_q   <= merged_d >> 40;
               res_q   <= 3'(total - 4'd5);
               count_q <= count_q + 16'd4;
               for (int n = 0; n < 4; n++) begin
                  pixel_q[n] <= {group[8*n +: 8], group[32 + 2*n +: 2]};
               end
            end else begin
               buf_q <= merged_d;
               res_q <= total[2:0];
            end
         end

         // Leftover residue bytes of a finished packet are dropped.
         if (packetEnd) begin
            buf_q <= '0;
            res_q <= '0;
            if (accept_q) begin
               line_pixel_count_q <= count_q;
               count_q            <= '0;
            end
         end

         if (packetEnd && accept_q && (res_q != 3'd0)) begin
            align_err_q <= 1'b1;
         end else if (bus.frame_start) begin
            align_err_q <= 1'b0;
         end
      end
   end

   assign bus.pixel            = pixel_q;
   assign bus.pixel_enable     = pixel_enable_q;
   assign bus.line_done        = line_done_q;
   assign bus.line_pixel_count = line_pixel_count_q;
   assign bus.align_err        = align_err_q;

endmodule

// File: tb/tb_raw10_unpacker.sv
// Directed bench for raw10_unpacker: hand-computed single group, seeded byte
// ramps for full lines, type filtering, error flag and mid-stream reset.
module tb_raw10_unpacker;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   raw10_unpacker_if bus ();

   raw10_unpacker #(.DATA_TYPE(6'h2B)) dut (
      .mipi_clk (clk),
      .reset_n  (rst_n),
      .bus      (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Group g of a ramp stream whose byte i has value seed+i.
   function automatic logic [39:0] expGroup(input int seed, input int g);
      logic [7:0]  b [5];
      logic [39:0] p;
      for (int k = 0; k < 5; k++) b[k] = 8'(seed + 5*g + k);
      for (int n = 0; n < 4; n++) p[10*n +: 10] = {b[n], b[4][2*n +: 2]};
      return p;
   endfunction

   task automatic driveBeat(input logic [31:0] d, input logic [5:0] t);
      bus.image_data        = d;
      bus.image_data_type   = t;
      bus.image_data_enable = 1'b1;
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic [5:0] dtype, input int nBeats, input int seed,
                                input bit accepted, input int fsBeat, input bit fsAtEnd,
                                input logic [15:0] expCount, input logic expAlign);
      int   pulses;
      logic expEn;
      pulses = 0;
      for (int b = 0; b < nBeats; b++) begin
         for (int j = 0; j < 4; j++) bus.image_data[j] = 8'(seed + 4*b + j);
         bus.image_data_type   = dtype;
         bus.image_data_enable = 1'b1;
         bus.frame_start       = (b == fsBeat);
         @(negedge clk);
         expEn = accepted && ((b % 5) != 0);
         checkOutput("pixel_enable", bus.pixel_enable, expEn);
         if (expEn) checkOutput("pixel", bus.pixel, expGroup(seed, (b / 5) * 4 + (b % 5) - 1));
         if (bus.pixel_enable) pulses++;
      end
      bus.image_data_enable = 1'b0;
      bus.frame_start       = fsAtEnd;
      @(negedge clk);
      bus.frame_start = 1'b0;
      checkOutput("group_pulses", pulses, accepted ? (4 * nBeats) / 5 : 0);
      checkOutput("line_done", bus.line_done, accepted);
      checkOutput("line_pixel_count", bus.line_pixel_count, expCount);
      checkOutput("align_err", bus.align_err, expAlign);
   endtask

   initial begin
      checks                = 0;
      errors                = 0;
      rst_n                 = 1'b0;
      bus.image_data        = '0;
      bus.image_data_type   = '0;
      bus.image_data_enable = 1'b0;
      bus.frame_start       = 1'b0;

      #12;
      checkOutput("rst_pixel", bus.pixel, 0);
      checkOutput("rst_pixel_enable", bus.pixel_enable, 0);
      checkOutput("rst_line_done", bus.line_done, 0);
      checkOutput("rst_count", bus.line_pixel_count, 0);
      checkOutput("rst_align_err", bus.align_err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Single group: B0..B3 = 10,20,30,40 and B4 = E4 -> residue 3 left over.
      driveBeat(32'h4030_2010, 6'h2B);
      checkOutput("sg_no_emit", bus.pixel_enable, 0);
      driveBeat(32'h0000_00E4, 6'h2B);
      checkOutput("sg_emit", bus.pixel_enable, 1);
      checkOutput("sg_pixel", bus.pixel, {10'h103, 10'h0C2, 10'h081, 10'h040});
      bus.image_data_enable = 1'b0;
      @(negedge clk);
      checkOutput("sg_line_done", bus.line_done, 1);
      checkOutput("sg_count", bus.line_pixel_count, 16'd4);
      checkOutput("sg_align_err", bus.align_err, 1);
      checkOutput("sg_pixel_enable_idle", bus.pixel_enable, 0);
      @(negedge clk);
      checkOutput("sg_line_done_pulse", bus.line_done, 0);
      checkOutput("sg_pixel_hold", bus.pixel, {10'h103, 10'h0C2, 10'h081, 10'h040});

      // Reset mid-packet, enable left high across the release.
      driveBeat(32'hA5A5_A5A5, 6'h2B);
      driveBeat(32'h5A5A_5A5A, 6'h2B);
      driveBeat(32'hC3C3_C3C3, 6'h2B);
      checkOutput("mid_emit", bus.pixel_enable, 1);
      #3 rst_n = 1'b0;
      #1;
      checkOutput("async_pixel", bus.pixel, 0);
      checkOutput("async_pixel_enable", bus.pixel_enable, 0);
      checkOutput("async_line_done", bus.line_done, 0);
      checkOutput("async_count", bus.line_pixel_count, 0);
      checkOutput("async_align_err", bus.align_err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(6'h2B, 200, 55, 1'b1, -1, 1'b0, 16'd640, 1'b0);

      // Foreign data type is dropped and the last count is kept.
      applyStimulus(6'h12, 200, 3, 1'b0, -1, 1'b0, 16'd640, 1'b0);

      // Three beats leave residue 2; frame_start clears, but loses to a new error.
      applyStimulus(6'h2B, 3, 100, 1'b1, -1, 1'b0, 16'd8, 1'b1);
      bus.frame_start = 1'b1;
      @(negedge clk);
      bus.frame_start = 1'b0;
      checkOutput("fs_clear", bus.align_err, 0);
      applyStimulus(6'h2B, 3, 200, 1'b1, -1, 1'b1, 16'd8, 1'b1);

      // Back-to-back lines, one idle cycle apart; frame_start lands on a beat.
      applyStimulus(6'h2B, 200, 17, 1'b1, 3, 1'b0, 16'd640, 1'b0);
      applyStimulus(6'h2B, 200, 90, 1'b1, -1, 1'b0, 16'd640, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
